irq_arbiter: RTL and testbench

//  Shares the core's single interrupt input between up to N_IRQ peripheral request lines
//  (switch, LED, UART, timer controllers). Each peripheral drives a level int_req and clears it
//  on a one-cycle int_fin pulse. Selects one masked, pending line and raises irq_o with its ID.

---
 rtl/irq_pkg.sv | 20 ++
 rtl/irq_arbiter_if.sv | 38 +++
 rtl/irq_prio_enc.sv | 42 ++++
 rtl/irq_arbiter.sv | 124 ++++++++++++
 tb/tb_irq_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// ----------------------------------------------------------------------------
// irq_pkg
//   Shared constants and types for the interrupt arbiter slice.
//   IRQ_ID_W  : width of the presented interrupt ID (holds 0..31)
//   MAX_N_IRQ : largest supported number of request lines
//   irq_state_e : arbiter sequencing states
// ----------------------------------------------------------------------------
package irq_pkg;

  localparam int unsigned IRQ_ID_W  = 5;
  localparam int unsigned MAX_N_IRQ = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2,
    FIN     = 2'd3
  } irq_state_e;

endpackage

// File: rtl/irq_arbiter_if.sv
// ----------------------------------------------------------------------------
// irq_arbiter_if
//   Bundles the peripheral request lines and the core-side interrupt handshake.
//   int_req : level requests from peripherals          (to arbiter)
//   mask    : per-line enable, 1 = enabled              (to arbiter)
//   irq_ack : one-cycle pulse, core entered the trap    (to arbiter)
//   irq_ret : one-cycle pulse, core executed mret       (to arbiter)
//   irq     : interrupt request to the core             (from arbiter)
//   irq_id  : index of presented/serviced line          (from arbiter)
//   int_fin : one-hot completion pulse to peripherals   (from arbiter)
//   busy    : high while a request is being serviced    (from arbiter)
//   modport master : arbiter side; modport slave : core/peripheral side.
// ----------------------------------------------------------------------------
interface irq_arbiter_if #(
  parameter int unsigned N_IRQ = 16
) ();
  import irq_pkg::*;

  logic [N_IRQ-1:0]    int_req;
  logic [N_IRQ-1:0]    mask;
  logic                irq_ack;
  logic                irq_ret;
  logic                irq;
  logic [IRQ_ID_W-1:0] irq_id;
  logic [N_IRQ-1:0]    int_fin;
  logic                busy;

  modport master (
    input  int_req, mask, irq_ack, irq_ret,
    output irq, irq_id, int_fin, busy
  );

  modport slave (
    output int_req, mask, irq_ack, irq_ret,
    input  irq, irq_id, int_fin, busy
  );

endinterface

// File: rtl/irq_prio_enc.sv
// ----------------------------------------------------------------------------
// irq_prio_enc
//   Combinational find-first-set over the pending vector, starting the search
//   at base_i and wrapping from N_IRQ-1 back to 0.
//   pending_i : masked request vector
//   base_i    : first index searched (must be < N_IRQ)
//   valid_o   : any pending bit found
//   idx_o     : index of the first pending bit at or after base_i
// ----------------------------------------------------------------------------
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int unsigned N_IRQ = 16
) (
  input  logic [N_IRQ-1:0]    pending_i,
  input  logic [IRQ_ID_W-1:0] base_i,
  output logic                valid_o,
  output logic [IRQ_ID_W-1:0] idx_o
);

  always_comb begin
    int unsigned      w_k;
    logic [N_IRQ-1:0] w_shifted;
    valid_o   = 1'b0;
    idx_o     = '0;
    w_k       = 0;
    w_shifted = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      w_k = 32'(base_i) + i;
      if (w_k >= N_IRQ) begin
        w_k = w_k - N_IRQ;
      end
      // Shift instead of a variable bit-select keeps the index width independent of N_IRQ.
      w_shifted = pending_i >> w_k;
      if (!valid_o && w_shifted[0]) begin
        valid_o = 1'b1;
        idx_o   = IRQ_ID_W'(w_k);
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// ----------------------------------------------------------------------------
// irq_arbiter
//   Shares the core's single interrupt input between N_IRQ peripheral request
//   lines. Picks one masked pending line, presents it on irq/irq_id, follows
//   the ack (trap entry) and ret (mret) pulses, then returns a one-cycle
//   int_fin pulse to the served peripheral only. All outputs are registered.
//
//   clk_i  : clock
//   rst_i  : asynchronous, active-high reset
//   bus    : irq_arbiter_if.master (int_req, mask, irq_ack, irq_ret in;
//            irq, irq_id, int_fin, busy out)
//
//   Build option IRQ_ARB_ROUND_ROBIN_EN: rotating priority starting at the line
//   after the last one served. Without it, lowest index wins.
// ----------------------------------------------------------------------------
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int unsigned N_IRQ = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  irq_arbiter_if.master  bus
);

  irq_state_e          r_state, w_state_d;
  logic [IRQ_ID_W-1:0] r_id, w_id_d;
  logic [IRQ_ID_W-1:0] w_base;
  logic [N_IRQ-1:0]    w_pending;
  logic                w_enc_valid;
  logic [IRQ_ID_W-1:0] w_enc_idx;
  logic                w_id_pending;

  logic                r_irq;
  logic                r_busy;
  logic [IRQ_ID_W-1:0] r_irq_id;
  logic [N_IRQ-1:0]    r_fin;

  assign w_pending    = bus.int_req & bus.mask;
  assign w_id_pending = |(w_pending & (N_IRQ'(1) << r_id));

`ifdef IRQ_ARB_ROUND_ROBIN_EN
  logic [IRQ_ID_W-1:0] r_rr_ptr;

  assign w_base = r_rr_ptr;

  // Next search starts just after the line that completed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
    end else if (r_state == FIN) begin
      r_rr_ptr <= (r_id == IRQ_ID_W'(N_IRQ - 1)) ? '0 : r_id + IRQ_ID_W'(1);
    end
  end
`else
  assign w_base = '0;
`endif

  irq_prio_enc #(
    .N_IRQ (N_IRQ)
  ) u_prio_enc (
    .pending_i (w_pending),
    .base_i    (w_base),
    .valid_o   (w_enc_valid),
    .idx_o     (w_enc_idx)
  );

  always_comb begin
    w_state_d = r_state;
    w_id_d    = r_id;
    unique case (r_state)
      IDLE: begin
        if (w_enc_valid) begin
          w_state_d = ASSERT;
          w_id_d    = w_enc_idx;
        end
      end
      ASSERT: begin
        // Ack takes priority over a same-cycle withdrawal.
        if (bus.irq_ack) begin
          w_state_d = SERVICE;
        end else if (!w_id_pending) begin
          w_state_d = IDLE;
        end
      end
      SERVICE: begin
        if (bus.irq_ret) begin
          w_state_d = FIN;
        end
      end
      FIN: begin
        w_state_d = IDLE;
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered decodes of the next state so they line up with r_state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_id     <= '0;
      r_irq    <= 1'b0;
      r_busy   <= 1'b0;
      r_irq_id <= '0;
      r_fin    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_id     <= w_id_d;
      r_irq    <= (w_state_d == ASSERT);
      r_busy   <= (w_state_d == SERVICE);
      r_irq_id <= (w_state_d == IDLE) ? '0 : w_id_d;
      r_fin    <= (w_state_d == FIN) ? (N_IRQ'(1) << w_id_d) : '0;
    end
  end

  assign bus.irq     = r_irq;
  assign bus.busy    = r_busy;
  assign bus.irq_id  = r_irq_id;
  assign bus.int_fin = r_fin;

endmodule

// File: tb/tb_irq_arbiter.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_irq_arbiter
//   Self-checking bench for irq_arbiter. Acts as core and peripherals, predicts
//   the served line from the arbitration rule and checks the handshake timing.
// ----------------------------------------------------------------------------
module tb_irq_arbiter;
  import irq_pkg::*;

  localparam int unsigned N = 16;

  logic clk = 1'b0;
  logic rst_i;

  always #5 clk = ~clk;

  irq_arbiter_if #(.N_IRQ(N)) bus ();

  irq_arbiter #(
    .N_IRQ (N)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned m_ptr = 0;  // model: first line searched

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_irq"},  32'(bus.irq), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_id"},   32'(bus.irq_id), 32'd0);
    check({tag, "_fin"},  32'(bus.int_fin), 32'd0);
  endtask

  // Served line: first pending line at or after 'start', wrapping around.
  function automatic int model_winner(input logic [N-1:0] pend, input int unsigned start);
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned k;
      k = (start + i) % N;
      if (pend[k]) return int'(k);
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int id);
    logic [N-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // One transaction from a clean idle at a negedge.
  // mode 0: ack then ret; 1: withdraw before ack; 2: ack with same-cycle withdraw.
  task automatic serve(input logic [N-1:0] req, input logic [N-1:0] msk, input int mode,
                       input int n_svc, output int obs_id);
    int exp_id;
    exp_id = model_winner(req & msk, m_ptr);
    bus.int_req = req;
    bus.mask    = msk;
    @(negedge clk);
    obs_id = int'(bus.irq_id);
    check("assert_irq",  32'(bus.irq), 32'd1);
    check("assert_id",   32'(bus.irq_id), 32'(exp_id));
    check("assert_busy", 32'(bus.busy), 32'd0);
    if (mode == 1) begin
      bus.mask = msk & ~onehot(exp_id);
      @(negedge clk);
      check("withdraw_irq", 32'(bus.irq), 32'd0);
      check("withdraw_fin", 32'(bus.int_fin), 32'd0);
      bus.int_req = '0;
      @(negedge clk);
      check_idle("withdraw_idle");
      return;
    end
    bus.irq_ack = 1'b1;
    if (mode == 2) bus.mask = msk & ~onehot(exp_id);
    @(negedge clk);
    bus.irq_ack = 1'b0;
    check("svc_irq",  32'(bus.irq), 32'd0);
    check("svc_busy", 32'(bus.busy), 32'd1);
    check("svc_id",   32'(bus.irq_id), 32'(exp_id));
    check("svc_fin",  32'(bus.int_fin), 32'd0);
    // Requests, mask and stray acks must all be ignored while servicing.
    for (int i = 0; i < n_svc; i++) begin
      bus.int_req = N'($urandom);
      bus.mask    = N'($urandom);
      bus.irq_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("svc_hold_busy", 32'(bus.busy), 32'd1);
      check("svc_hold_irq",  32'(bus.irq), 32'd0);
      check("svc_hold_id",   32'(bus.irq_id), 32'(exp_id));
      check("svc_hold_fin",  32'(bus.int_fin), 32'd0);
    end
    bus.irq_ack = 1'b0;
    bus.irq_ret = 1'b1;
    bus.int_req = '0;
    @(negedge clk);
    bus.irq_ret = 1'b0;
    check("fin_pulse", 32'(bus.int_fin), 32'(onehot(exp_id)));
    check("fin_busy",  32'(bus.busy), 32'd0);
    check("fin_irq",   32'(bus.irq), 32'd0);
    check("fin_id",    32'(bus.irq_id), 32'(exp_id));
    @(negedge clk);
    check_idle("after_fin");
`ifdef IRQ_ARB_ROUND_ROBIN_EN
    m_ptr = (int'(exp_id) + 1) % N;
`endif
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    m_ptr = 0;
    @(negedge clk);
  endtask

  initial begin
    int id;
    logic [N-1:0] req, msk;

    rst_i       = 1'b1;
    bus.int_req = '0;
    bus.mask    = '0;
    bus.irq_ack = 1'b0;
    bus.irq_ret = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_i = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    // Single request on line 3.
    serve(16'h0008, 16'hFFFF, 0, 1, id);
    check("t1_id", 32'(id), 32'd3);

    // Two lines: lower index first, then the remaining one.
    serve(16'h0014, 16'hFFFF, 0, 0, id);
    check("t2_first", 32'(id), 32'd2);
    serve(16'h0010, 16'hFFFF, 0, 0, id);
    check("t2_second", 32'(id), 32'd4);

    // Masked request never presented.
    bus.int_req = 16'h0002;
    bus.mask    = 16'hFFFD;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t3_masked_irq", 32'(bus.irq), 32'd0);
    end
    serve(16'h0002, 16'hFFFF, 0, 0, id);
    check("t3_unmasked_id", 32'(id), 32'd1);

    // Withdraw before ack, then same-cycle ack + withdraw.
    serve(16'h0020, 16'hFFFF, 1, 0, id);
    serve(16'h0020, 16'hFFFF, 2, 1, id);

    // Stray ret/ack while idle are ignored.
    bus.irq_ret = 1'b1;
    bus.irq_ack = 1'b1;
    @(negedge clk);
    bus.irq_ret = 1'b0;
    bus.irq_ack = 1'b0;
    check_idle("stray_pulse");

    // Reset in the middle of SERVICE.
    bus.int_req = 16'h0100;
    bus.mask    = 16'hFFFF;
    @(negedge clk);
    bus.irq_ack = 1'b1;
    @(negedge clk);
    bus.irq_ack = 1'b0;
    check("t5_in_service", 32'(bus.busy), 32'd1);
    #2 rst_i = 1'b1;
    #1 check_idle("t5_async_reset");
    bus.irq_ret = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_fin", 32'(bus.int_fin), 32'd0);
      bus.irq_ret = 1'b0;
    end
    rst_i = 1'b0;
    m_ptr = 0;
    serve(16'h0100, 16'hFFFF, 0, 0, id);
    check("t5_represent", 32'(id), 32'd8);

    // Lines 0 and 1 re-raised after every fin.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      serve(16'h0003, 16'hFFFF, 0, 0, id);
`ifdef IRQ_ARB_ROUND_ROBIN_EN
      check("t6_rr_order", 32'(id), 32'(i % 2));
`else
      check("t6_fixed_order", 32'(id), 32'd0);
`endif
    end

    // Randomized transactions against the model.
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.irq_ret = 1'($urandom_range(0, 1));
        bus.irq_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus.irq_ret = 1'b0;
        bus.irq_ack = 1'b0;
        check_idle("rand_stray");
      end
      req = N'($urandom);
      msk = N'($urandom);
      if ((req & msk) == '0) begin
        int b;
        b = int'($urandom_range(0, N - 1));
        req[b] = 1'b1;
        msk[b] = 1'b1;
      end
      serve(req, msk, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), id);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
